recovery_regfile_ckpt: RTL

Parametrised checkpoint register file for the TMR RISC-V core. It captures architectural register writes, tracks which entries hold valid checkpoint data, and on request replays every valid entry over a valid/ready stream. This stream re-seeds the voted register file after a TMR fault. Multi-port combinational reads remain available for the voter and debug logic.

---
 rtl/recovery_pkg.sv | 18 +
 rtl/recovery_replay_fsm.sv | 70 +++++++
 rtl/recovery_regfile_ckpt.sv | 95 +++++++++
 3 files changed

// File: rtl/recovery_pkg.sv
// Shared types and defaults for the TMR recovery path (checkpoint regfile, voter, TMR regfile).
package recovery_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Address width for a given depth; never returns less than one bit.
    function automatic int clog2(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/recovery_replay_fsm.sv
// Replay sequencer: walks every index once, presenting valid entries as stream beats.
// One cycle per skipped entry; a presented beat holds until rs_ready.
module recovery_replay_fsm
    import recovery_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restore_req,
    input  logic [DEPTH-1:0]  valid,
    input  logic              rs_ready,
    output logic              rs_valid,
    output logic [ADDR_W-1:0] rs_addr,
    output logic              restore_busy,
    output logic              restore_done
);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              advance;
    logic              last;

    // Valid bits are frozen while busy, so a presented beat cannot change under the consumer.
    assign rs_valid = (state == SCAN) && valid[idx];
    assign rs_addr  = idx;
    assign advance  = !valid[idx] || rs_ready;
    assign last     = (idx == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            restore_busy <= 1'b0;
            restore_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (restore_req) begin
                        state        <= SCAN;
                        idx          <= '0;
                        restore_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (advance) begin
                        if (last) begin
                            state        <= DONE;
                            restore_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    restore_busy <= 1'b0;
                    restore_done <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    restore_busy <= 1'b0;
                    restore_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/recovery_regfile_ckpt.sv
// Checkpoint register file: captures architectural writes, serves combinational reads,
// and replays valid entries over a valid/ready stream to re-seed the voted regfile.
module recovery_regfile_ckpt
    import recovery_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    parameter  int DEPTH  = DEF_DEPTH,
    parameter  int NUM_RD = 2,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_in,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     ckpt_clr,
    input  logic                     restore_req,
    output logic                     rs_valid,
    input  logic                     rs_ready,
    output logic [ADDR_W-1:0]        rs_addr,
    output logic [DATA_W-1:0]        rs_data,
    output logic                     restore_busy,
    output logic                     restore_done,
    output logic                     wr_drop,
    output logic [ADDR_W:0]          valid_count
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [ADDR_W:0]   count_nxt;
    logic              wr_ok;
    logic              clr_ok;

    assign wr_ok  = we && ({1'b0, waddr} < DEPTH_W) && !restore_busy;
    assign clr_ok = ckpt_clr && !restore_busy && !restore_req;

    // A clear with a same-cycle write leaves exactly the written entry valid.
    always_comb begin
        valid_nxt = clr_ok ? '0 : valid;
        count_nxt = clr_ok ? '0 : valid_count;
        if (wr_ok) begin
            valid_nxt[waddr] = 1'b1;
            if (clr_ok || !valid[waddr]) begin
                count_nxt = count_nxt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            valid       <= '0;
            valid_count <= '0;
            wr_drop     <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[waddr] <= wdata;
            end
            valid       <= valid_nxt;
            valid_count <= count_nxt;
            wr_drop     <= we && !wr_ok;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_data[k*DATA_W +: DATA_W] =
            (({1'b0, a} < DEPTH_W) && valid[a]) ? mem[a] : '0;
    end

    assign rs_data = mem[rs_addr];

    recovery_replay_fsm #(
        .DEPTH (DEPTH)
    ) u_fsm (
        .clk          (clk),
        .rst          (rst_in),
        .restore_req  (restore_req),
        .valid        (valid),
        .rs_ready     (rs_ready),
        .rs_valid     (rs_valid),
        .rs_addr      (rs_addr),
        .restore_busy (restore_busy),
        .restore_done (restore_done)
    );

endmodule
